// File: rtl/prng_pkg.sv
// Shared types, constants and the LFSR step function for the PRNG arbiter slice.
// Optional reseed port set is controlled by PRNG_ARB_RESEED_EN.
package prng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ADVANCE = 2'd2
  } prng_state_e;

  localparam logic [63:0] PRNG_DEFAULT_SEED = 64'h128F_9A75_D093_C27E;
  localparam logic [63:0] PRNG_LOCKUP       = '1;

  localparam int unsigned PRNG_TAP0 = 63;
  localparam int unsigned PRNG_TAP1 = 62;
  localparam int unsigned PRNG_TAP2 = 60;
  localparam int unsigned PRNG_TAP3 = 59;

  // XNOR feedback: all-ones is the only lock-up state, so it must never be loaded.
  function automatic logic [63:0] prng_next(input logic [63:0] s);
    return {s[62:0], ~(s[PRNG_TAP0] ^ s[PRNG_TAP1] ^ s[PRNG_TAP2] ^ s[PRNG_TAP3])};
  endfunction

endpackage

// File: rtl/prng_arbiter_if.sv
// Requester-side bus of the PRNG arbiter: request/grant handshake plus random data.
// seed_wr/seed_data exist only when PRNG_ARB_RESEED_EN is defined.
interface prng_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [63:0]        rand_data;
  logic               rand_valid;
  logic               busy;

`ifdef PRNG_ARB_RESEED_EN
  logic               seed_wr;
  logic [63:0]        seed_data;

  modport master (
    output req, seed_wr, seed_data,
    input  gnt, rand_data, rand_valid, busy
  );

  modport slave (
    input  req, seed_wr, seed_data,
    output gnt, rand_data, rand_valid, busy
  );
`else
  modport master (
    output req,
    input  gnt, rand_data, rand_valid, busy
  );

  modport slave (
    input  req,
    output gnt, rand_data, rand_valid, busy
  );
`endif

endinterface

// File: rtl/prng_lfsr64.sv
// 64-bit XNOR-feedback LFSR register; load takes priority over step.
module prng_lfsr64
  import prng_pkg::*;
#(
  parameter logic [63:0] SEED = PRNG_DEFAULT_SEED
) (
  input  logic        procClock,
  input  logic        reset,
  input  logic        step,
  input  logic        load,
  input  logic [63:0] load_value,
  output logic [63:0] q
);

  always_ff @(posedge procClock) begin
    if (reset) begin
      q <= SEED;
    end else if (load) begin
      q <= load_value;
    end else if (step) begin
      q <= prng_next(q);
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter sharing one 64-bit LFSR among NUM_REQ requesters.
// Define PRNG_ARB_RESEED_EN to enable runtime reseeding via seed_wr/seed_data.
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned STEPS_PER_GRANT = 1,
  parameter logic [63:0] SEED            = PRNG_DEFAULT_SEED
) (
  input  logic           procClock,
  input  logic           reset,
  prng_arbiter_if.slave  bus
);

  localparam int unsigned    PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [63:0]    RESET_SEED = (SEED == PRNG_LOCKUP) ? PRNG_DEFAULT_SEED : SEED;
  localparam logic [5:0]     CNT_LOAD   = 6'(STEPS_PER_GRANT - 1);
  localparam logic [PW-1:0]  LAST_IDX   = PW'(NUM_REQ - 1);

  prng_state_e        state, state_n;
  logic [PW-1:0]      rr_ptr, rr_ptr_n;
  logic [PW-1:0]      winner, winner_n;
  logic [5:0]         cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;

  logic [PW-1:0]      cand;
  logic [PW-1:0]      scan_idx;
  logic               scan_hit;

  logic               step;
  logic               load;
  logic [63:0]        load_value;
  logic [63:0]        lfsr_q;

  prng_lfsr64 #(
    .SEED (RESET_SEED)
  ) u_lfsr (
    .procClock  (procClock),
    .reset      (reset),
    .step       (step),
    .load       (load),
    .load_value (load_value),
    .q          (lfsr_q)
  );

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = rr_ptr;
    cand     = rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PW'((32'(rr_ptr) + i) % NUM_REQ);
      if (!scan_hit && bus.req[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    winner_n   = winner;
    cnt_n      = cnt;
    gnt_n      = '0;
    step       = 1'b0;
    load       = 1'b0;
    load_value = RESET_SEED;

    case (state)
      IDLE: begin
        if (scan_hit) begin
          winner_n = scan_idx;
          gnt_n    = NUM_REQ'(1) << scan_idx;
          state_n  = GRANT;
        end
      end
      GRANT: begin
        rr_ptr_n = (winner == LAST_IDX) ? '0 : winner + 1'b1;
        cnt_n    = CNT_LOAD;
        state_n  = ADVANCE;
      end
      ADVANCE: begin
        step = 1'b1;
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

`ifdef PRNG_ARB_RESEED_EN
    // Reseed overrides stepping and any pending grant, but a grant already
    // on gnt completes and its rr_ptr update is kept.
    if (bus.seed_wr) begin
      load       = 1'b1;
      step       = 1'b0;
      load_value = (bus.seed_data == PRNG_LOCKUP) ? RESET_SEED : bus.seed_data;
      state_n    = IDLE;
      cnt_n      = '0;
      gnt_n      = '0;
    end
`endif
  end

  always_ff @(posedge procClock) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      winner <= '0;
      cnt    <= '0;
      gnt_q  <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      winner <= winner_n;
      cnt    <= cnt_n;
      gnt_q  <= gnt_n;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rand_valid = |gnt_q;
  assign bus.busy       = (state != IDLE);
  assign bus.rand_data  = lfsr_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Bench for prng_arbiter: two instances (1 and 4 steps per grant) checked every cycle
// against a cycle-count model, plus directed literal checks.
module tb_prng_arbiter;

  localparam logic [63:0] SEED = 64'h128F_9A75_D093_C27E;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prng_arbiter_if #(.NUM_REQ(4)) bus_a ();
  prng_arbiter_if #(.NUM_REQ(4)) bus_b ();

  prng_arbiter #(
    .NUM_REQ         (4),
    .STEPS_PER_GRANT (1),
    .SEED            (SEED)
  ) dut_a (
    .procClock (clk),
    .reset     (rst),
    .bus       (bus_a)
  );

  prng_arbiter #(
    .NUM_REQ         (4),
    .STEPS_PER_GRANT (4),
    .SEED            (SEED)
  ) dut_b (
    .procClock (clk),
    .reset     (rst),
    .bus       (bus_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: per instance, the LFSR value, rr pointer, expected gnt and the number
  // of busy cycles still to come (grant cycle + steps).
  int          steps   [2] = '{1, 4};
  logic [63:0] m_lfsr  [2];
  int          m_ptr   [2];
  int          m_left  [2];
  logic [3:0]  m_gnt   [2];
  bit          m_started = 1'b0;

  function automatic logic [63:0] sw_step(input logic [63:0] s);
    return {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
  endfunction

  always @(posedge clk) begin
    logic [3:0]  r;
    logic        sw;
    logic [63:0] sd;
    int          c;
    for (int k = 0; k < 2; k++) begin
      r  = (k == 0) ? bus_a.req : bus_b.req;
      sw = 1'b0;
      sd = '0;
`ifdef PRNG_ARB_RESEED_EN
      sw = (k == 0) ? bus_a.seed_wr : bus_b.seed_wr;
      sd = (k == 0) ? bus_a.seed_data : bus_b.seed_data;
`endif
      if (rst) begin
        m_lfsr[k] = SEED;
        m_ptr[k]  = 0;
        m_left[k] = 0;
        m_gnt[k]  = '0;
      end else if (sw) begin
        m_lfsr[k] = (sd == 64'hFFFF_FFFF_FFFF_FFFF) ? SEED : sd;
        m_left[k] = 0;
        m_gnt[k]  = '0;
      end else if (m_left[k] == 0) begin
        m_gnt[k] = '0;
        for (int i = 0; i < 4; i++) begin
          c = (m_ptr[k] + i) % 4;
          if (r[c] && m_gnt[k] == 4'b0) begin
            m_gnt[k] = 4'(1 << c);
            m_ptr[k] = (c + 1) % 4;
          end
        end
        if (m_gnt[k] != 4'b0) m_left[k] = steps[k] + 1;
      end else begin
        if (m_left[k] <= steps[k]) m_lfsr[k] = sw_step(m_lfsr[k]);
        m_left[k] = m_left[k] - 1;
        m_gnt[k]  = '0;
      end
    end
    m_started = 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    check("gnt_a",   64'(bus_a.gnt),        64'(m_gnt[0]));
    check("valid_a", 64'(bus_a.rand_valid), 64'(m_gnt[0] != 4'b0));
    check("busy_a",  64'(bus_a.busy),       64'(m_left[0] != 0));
    if (m_gnt[0] != 4'b0) check("data_a", bus_a.rand_data, m_lfsr[0]);
    check("gnt_b",   64'(bus_b.gnt),        64'(m_gnt[1]));
    check("valid_b", 64'(bus_b.rand_valid), 64'(m_gnt[1] != 4'b0));
    check("busy_b",  64'(bus_b.busy),       64'(m_left[1] != 0));
    if (m_gnt[1] != 4'b0) check("data_b", bus_b.rand_data, m_lfsr[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (m_started) compare_all();
  endtask

  task automatic wait_gnt(input int k, output logic [3:0] g, output logic [63:0] d,
                          output int at);
    g  = '0;
    d  = '0;
    at = cyc;
    for (int n = 0; n < 20; n++) begin
      tick();
      g = (k == 0) ? bus_a.gnt : bus_b.gnt;
      if (g != 4'b0) begin
        d  = (k == 0) ? bus_a.rand_data : bus_b.rand_data;
        at = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout dut=%0d actual=no grant required=grant within 20 cycles", k);
  endtask

  logic [3:0]  g;
  logic [63:0] d, d1, d2, mdl;
  int          at, prev_at, bcount;
  logic [3:0]  exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst       = 1'b1;
    bus_a.req = '0;
    bus_b.req = '0;
`ifdef PRNG_ARB_RESEED_EN
    bus_a.seed_wr   = 1'b0;
    bus_a.seed_data = '0;
    bus_b.seed_wr   = 1'b0;
    bus_b.seed_data = '0;
`endif
    tick();
    tick();
    check("rst_gnt",   64'(bus_a.gnt),        64'h0);
    check("rst_valid", 64'(bus_a.rand_valid), 64'h0);
    check("rst_busy",  64'(bus_a.busy),       64'h0);
    check("rst_data",  bus_a.rand_data,       SEED);
    rst = 1'b0;

    // single requester: grant next cycle, busy two cycles
    bus_a.req = 4'b0001;
    tick();
    check("t1_gnt",  64'(bus_a.gnt),  64'h1);
    check("t1_data", bus_a.rand_data, 64'h128F_9A75_D093_C27E);
    check("t1_busy_grant", 64'(bus_a.busy), 64'h1);
    bus_a.req = '0;
    tick();
    check("t1_busy_adv", 64'(bus_a.busy), 64'h1);
    check("t1_gnt_adv",  64'(bus_a.gnt),  64'h0);
    tick();
    check("t1_idle", 64'(bus_a.busy), 64'h0);

    bus_a.req = 4'b0001;
    tick();
    check("t2_gnt",  64'(bus_a.gnt),  64'h1);
    check("t2_data", bus_a.rand_data, 64'h251F_34EB_A127_84FC);
    bus_a.req = '0;
    tick();
    tick();

    // rr pointer now 1: 0110 goes to requester 1, then requester 2
    bus_a.req = 4'b0110;
    tick();
    check("rr_first", 64'(bus_a.gnt), 64'h2);
    bus_a.req = '0;
    tick();
    tick();
    bus_a.req = 4'b0110;
    tick();
    check("rr_second", 64'(bus_a.gnt), 64'h4);
    bus_a.req = '0;
    tick();
    tick();

    // all requesting from reset
    rst       = 1'b1;
    bus_a.req = 4'b1111;
    tick();
    tick();
    rst     = 1'b0;
    prev_at = 0;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(0, g, d, at);
      check($sformatf("t3_order%0d", n), 64'(g), 64'(exp_order[n]));
      if (n > 0) check($sformatf("t3_spacing%0d", n), 64'(at - prev_at), 64'd3);
      prev_at = at;
    end
    bus_a.req = '0;
    tick();
    tick();
    tick();

    // four steps per grant
    bus_b.req = 4'b0010;
    wait_gnt(1, g, d1, at);
    bus_b.req = '0;
    bcount = 1;
    for (int n = 0; n < 10 && bus_b.busy; n++) begin
      tick();
      if (bus_b.busy) bcount++;
    end
    check("t4_busy1", 64'(bcount), 64'd5);
    bus_b.req = 4'b0010;
    wait_gnt(1, g, d2, at);
    bus_b.req = '0;
    bcount = 1;
    for (int n = 0; n < 10 && bus_b.busy; n++) begin
      tick();
      if (bus_b.busy) bcount++;
    end
    check("t4_busy2", 64'(bcount), 64'd5);
    mdl = d1;
    for (int n = 0; n < 4; n++) mdl = sw_step(mdl);
    check("t4_first",  d1, SEED);
    check("t4_model",  d2, mdl);
    check("t4_second", d2, 64'h28F9_A75D_093C_27E7);

    // reset during ADVANCE after one step has happened
    bus_b.req = 4'b0010;
    wait_gnt(1, g, d, at);
    bus_b.req = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5_gnt",  64'(bus_b.gnt),  64'h0);
    check("t5_busy", 64'(bus_b.busy), 64'h0);
    check("t5_lfsr", bus_b.rand_data, SEED);
    rst       = 1'b0;
    bus_b.req = 4'b0001;
    wait_gnt(1, g, d, at);
    bus_b.req = '0;
    check("t5_regrant_gnt",  64'(g), 64'h1);
    check("t5_regrant_data", d,      SEED);
    for (int n = 0; n < 6; n++) tick();

`ifdef PRNG_ARB_RESEED_EN
    bus_a.seed_wr   = 1'b1;
    bus_a.seed_data = 64'h0000_0000_0000_0001;
    tick();
    bus_a.seed_wr = 1'b0;
    bus_a.req     = 4'b0100;
    wait_gnt(0, g, d, at);
    bus_a.req = '0;
    check("t6_gnt",  64'(g), 64'h4);
    check("t6_data", d,      64'h1);
    tick();
    tick();
    bus_a.seed_wr   = 1'b1;
    bus_a.seed_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus_a.seed_wr = 1'b0;
    bus_a.req     = 4'b0001;
    wait_gnt(0, g, d, at);
    bus_a.req = '0;
    check("t6_lockup_data", d, SEED);
    tick();
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
